// File: rtl/as2650_mem_pkg.sv
// Shared types and the arbitration helper for the AS2650 external SRAM arbiter.
// The arbitration helper also covers round-robin mode; as2650_mem_arbiter selects it with AS2650_ARB_ROUNDROBIN_EN.
package as2650_mem_pkg;

  localparam int WAIT_MAX = 7;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
  typedef enum logic {GNT_CPU, GNT_WB} grant_e;

  // Contention goes to whoever was not served last when rr_en is set, otherwise the CPU wins.
  function automatic grant_e pick_grant(input logic   cpu_req,
                                        input logic   wb_req,
                                        input logic   rr_en,
                                        input grant_e last_grant);
    if (cpu_req && wb_req && rr_en)
      return (last_grant == GNT_CPU) ? GNT_WB : GNT_CPU;
    return cpu_req ? GNT_CPU : GNT_WB;
  endfunction

endpackage

// File: rtl/as2650_mem_arbiter.sv
// Shares one asynchronous SRAM port between the AS2650 CPU bus and the Caravel Wishbone slave.
// Each access runs IDLE -> SETUP -> ACCESS x (WAIT_STATES+1) -> DONE.
// Define AS2650_ARB_ROUNDROBIN_EN to alternate grants under contention; the default gives the CPU fixed priority.
module as2650_mem_arbiter
  import as2650_mem_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int WAIT_STATES = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_data_oeb
);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_bad_wait_states
      $error("as2650_mem_arbiter: WAIT_STATES must be within 0..7");
    end
  endgenerate

  state_e             state;
  grant_e             gnt;
  grant_e             next_gnt;
  logic               wb_req;
  logic               lat_we;
  logic               lat_be;
  logic [CNT_W-1:0]   wait_cnt;
  logic [7:0]         cpu_rd_q;
  logic [7:0]         wb_rd_q;
  logic               win_we;
  logic               win_be;
  logic [ADDR_W-1:0]  win_addr;
  logic [7:0]         win_wdata;

  // Only the low byte lane and the SRAM-sized part of the address exist on this port.
  wire unused_wb_bits = ^{wbs_sel_i[3:1], wbs_adr_i[31:ADDR_W], wbs_dat_i[31:8]};

  assign wb_req = wbs_cyc_i & wbs_stb_i;

`ifdef AS2650_ARB_ROUNDROBIN_EN
  grant_e last_grant;

  assign next_gnt = pick_grant(cpu_req, wb_req, 1'b1, last_grant);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      last_grant <= GNT_WB;
    else if (state == IDLE && (cpu_req || wb_req))
      last_grant <= next_gnt;
  end
`else
  assign next_gnt = pick_grant(cpu_req, wb_req, 1'b0, GNT_WB);
`endif

  always_comb begin
    win_we    = wbs_we_i;
    win_be    = wbs_sel_i[0];
    win_addr  = wbs_adr_i[ADDR_W-1:0];
    win_wdata = wbs_dat_i[7:0];
    if (next_gnt == GNT_CPU) begin
      win_we    = cpu_we;
      win_be    = 1'b1;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
    end
  end

  assign cpu_rdata = cpu_rd_q;
  assign wbs_dat_o = {24'h0, wb_rd_q};

  // NOTE: all state and pad strobes update with <= so every branch sees the pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      gnt          <= GNT_WB;
      lat_we       <= 1'b0;
      lat_be       <= 1'b0;
      wait_cnt     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_ce_n     <= 1'b1;
      mem_oe_n     <= 1'b1;
      mem_we_n     <= 1'b1;
      mem_data_oeb <= 1'b1;
      cpu_ack      <= 1'b0;
      wbs_ack_o    <= 1'b0;
      cpu_rd_q     <= '0;
      wb_rd_q      <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      wbs_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          mem_ce_n     <= 1'b1;
          mem_oe_n     <= 1'b1;
          mem_we_n     <= 1'b1;
          mem_data_oeb <= 1'b1;
          if (cpu_req || wb_req) begin
            gnt          <= next_gnt;
            lat_we       <= win_we;
            lat_be       <= win_be;
            mem_addr     <= win_addr;
            if (win_we)
              mem_wdata  <= win_wdata;
            mem_ce_n     <= 1'b0;
            mem_oe_n     <= win_we;
            mem_data_oeb <= ~win_we;
            state        <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= CNT_W'(WAIT_STATES);
          // A Wishbone write with byte lane 0 disabled still runs the cycle, but never strobes the SRAM.
          mem_we_n <= ~(lat_we & lat_be);
          state    <= ACCESS;
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            mem_we_n <= 1'b1;
            mem_oe_n <= 1'b1;
            state    <= DONE;
            if (gnt == GNT_CPU) begin
              cpu_ack <= 1'b1;
              if (!lat_we)
                cpu_rd_q <= mem_rdata;
            end else begin
              wbs_ack_o <= 1'b1;
              if (!lat_we)
                wb_rd_q <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          // Chip enable is released one cycle after the write strobe for address hold.
          mem_ce_n     <= 1'b1;
          mem_data_oeb <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_as2650_mem_arbiter.sv
// Self-checking bench for as2650_mem_arbiter: randomized accesses checked against a memory-content model.
// Expects alternating contention grants when compiled with AS2650_ARB_ROUNDROBIN_EN.
`timescale 1ns/1ps
module tb_as2650_mem_arbiter;

  localparam int ADDR_W = 15;
  localparam int WS     = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata, cpu_rdata;
  logic              cpu_ack;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic              wbs_ack_o;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  as2650_mem_arbiter #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_data_oeb(mem_data_oeb)
  );

  // Power-up SRAM contents; 0x0100 holds 0xA5.
  function automatic logic [7:0] init_byte(input logic [14:0] a);
    if (a == 15'h0100) return 8'hA5;
    return a[7:0] ^ {a[14:8], 1'b1};
  endfunction

  // SRAM environment: a byte is committed when WE rises while CE is still low.
  logic [7:0] sram_wr [logic [14:0]];
  logic       prev_we_n = 1'b1;

  function automatic logic [7:0] sram_peek(input logic [14:0] a);
    return sram_wr.exists(a) ? sram_wr[a] : init_byte(a);
  endfunction

  always @(negedge clk) begin
    if (!prev_we_n && mem_we_n && !mem_ce_n)
      sram_wr[mem_addr] = mem_wdata;
    prev_we_n = mem_we_n;
    mem_rdata = (!mem_ce_n && !mem_oe_n) ? sram_peek(mem_addr) : 8'h00;
  end

  // Reference model: expected memory contents and expected read-data registers.
  logic [7:0] exp_mem [logic [14:0]];
  logic [7:0] exp_cpu_rd = 8'h00;
  logic [7:0] exp_wb_rd  = 8'h00;

  function automatic logic [7:0] exp_read(input logic [14:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
  endfunction

  task automatic drop_requests();
    cpu_req   = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  task automatic do_access(input bit is_wb, input bit we, input logic [14:0] addr,
                           input logic [7:0] wd, input logic [3:0] sel, input string tag);
    int         n = 0;
    int         n_oe = 0, n_we = 0, n_oeb = 0;
    bit         we_in_setup = 1'b0;
    bit         got = 1'b0;
    bit         effective;
    logic [7:0] rd = 8'h00;
    logic [7:0] exp_rd;
    exp_rd    = exp_read(addr);
    effective = we && (!is_wb || sel[0]);
    if (is_wb) begin
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
      wbs_adr_i = $urandom(); wbs_adr_i[14:0] = addr;
      wbs_dat_i = $urandom(); wbs_dat_i[7:0]  = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (is_wb) begin
          wbs_adr_i = ~wbs_adr_i; wbs_dat_i = ~wbs_dat_i; wbs_we_i = ~we; wbs_sel_i = ~sel;
        end else begin
          cpu_addr = ~addr; cpu_wdata = ~wd; cpu_we = ~we;
        end
      end
      if (!mem_oe_n) n_oe++;
      if (!mem_we_n) begin
        n_we++;
        if (n == 1) we_in_setup = 1'b1;
      end
      if (!mem_data_oeb) n_oeb++;
      if (is_wb ? wbs_ack_o : cpu_ack) begin
        got = 1'b1;
        rd  = is_wb ? wbs_dat_o[7:0] : cpu_rdata;
      end
    end
    drop_requests();
    n_cmp++;
    if (!got || n != 3 + WS) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles (acked=%0d), want %0d", tag, n, got, 3 + WS);
    end
    if (!we) begin
      if (is_wb) exp_wb_rd = exp_rd; else exp_cpu_rd = exp_rd;
      n_cmp++;
      if (rd !== exp_rd) begin
        n_err++;
        $display("FAIL %s rdata: got %h want %h", tag, rd, exp_rd);
      end
      n_cmp++;
      if (n_oe != WS + 2 || n_we != 0 || n_oeb != 0) begin
        n_err++;
        $display("FAIL %s read strobes: oe=%0d we=%0d oeb=%0d want %0d/0/0", tag, n_oe, n_we, n_oeb, WS + 2);
      end
    end else begin
      if (effective) exp_mem[addr] = wd;
      n_cmp++;
      if (n_oe != 0 || n_oeb != WS + 3 || n_we != (effective ? WS + 1 : 0) || we_in_setup) begin
        n_err++;
        $display("FAIL %s write strobes: oe=%0d oeb=%0d we=%0d we_in_setup=%0d want 0/%0d/%0d/0",
                 tag, n_oe, n_oeb, n_we, we_in_setup, WS + 3, effective ? WS + 1 : 0);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack, wbs_ack_o} !== 6'b111100) begin
      n_err++;
      $display("FAIL %s turnaround: ce/oe/we/oeb/cpu_ack/wb_ack=%b want 111100", tag,
               {mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack, wbs_ack_o});
    end
    n_cmp++;
    if (cpu_rdata !== exp_cpu_rd || wbs_dat_o !== {24'h0, exp_wb_rd}) begin
      n_err++;
      $display("FAIL %s held rdata: cpu=%h wb=%h want cpu=%h wb=%h", tag, cpu_rdata, wbs_dat_o,
               exp_cpu_rd, {24'h0, exp_wb_rd});
    end
    n_cmp++;
    if (sram_peek(addr) !== exp_read(addr)) begin
      n_err++;
      $display("FAIL %s sram byte %h: got %h want %h", tag, addr, sram_peek(addr), exp_read(addr));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    cpu_req = 1'b0;
    n_cmp++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack, wbs_ack_o} !== 6'b111100) begin
      n_err++;
      $display("FAIL reset strobes: got %b want 111100",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack, wbs_ack_o});
    end
    n_cmp++;
    if (mem_addr !== '0 || mem_wdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset mem bus: addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (cpu_rdata !== 8'h00 || wbs_dat_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset rdata: cpu=%h wb=%h want 0/0", cpu_rdata, wbs_dat_o);
    end
    rst = 1'b0;
    exp_cpu_rd = 8'h00;
    exp_wb_rd  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    do_access(1'b0, 1'b0, 15'h0100, 8'h00, 4'h1, "cpu_read_0100");
  endtask

  task automatic test_wb_write();
    do_access(1'b1, 1'b1, 15'h7FFF, 8'h3C, 4'h1, "wb_write_7fff");
    n_cmp++;
    if (sram_peek(15'h7FFF) !== 8'h3C) begin
      n_err++;
      $display("FAIL wb_write sram: got %h want 3c", sram_peek(15'h7FFF));
    end
    do_access(1'b1, 1'b0, 15'h7FFF, 8'h00, 4'h1, "wb_readback_7fff");
  endtask

  task automatic test_wb_write_nosel();
    do_access(1'b1, 1'b1, 15'h0055, 8'h99, 4'h0, "wb_write_sel0");
    n_cmp++;
    if (sram_peek(15'h0055) !== init_byte(15'h0055)) begin
      n_err++;
      $display("FAIL wb_write_sel0 sram: got %h want %h", sram_peek(15'h0055), init_byte(15'h0055));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit         is_wb;
      bit         we;
      logic [14:0] a;
      logic [7:0]  d;
      logic [3:0]  sel;
      is_wb = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      a     = 15'h0400 + 15'($urandom_range(0, 31));
      d     = 8'($urandom());
      sel   = 4'($urandom());
      do_access(is_wb, we, a, d, sel, is_wb ? "rand_wb" : "rand_cpu");
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] a [3];
    int          acks[$];
    int          n = 0;
    int          k = 0;
    bit          turn_pending = 1'b0;
    a[0] = 15'h0010; a[1] = 15'h0021; a[2] = 15'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a[0];
    while ((k < 3 || turn_pending) && n < 60) begin
      @(negedge clk);
      n++;
      if (turn_pending) begin
        turn_pending = 1'b0;
        n_cmp++;
        if ({mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack} !== 5'b11110) begin
          n_err++;
          $display("FAIL b2b turnaround %0d: got %b want 11110", k,
                   {mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack});
        end
      end
      if (cpu_ack && k < 3) begin
        n_cmp++;
        if (cpu_rdata !== exp_read(a[k])) begin
          n_err++;
          $display("FAIL b2b rdata %0d: got %h want %h", k, cpu_rdata, exp_read(a[k]));
        end
        exp_cpu_rd = exp_read(a[k]);
        acks.push_back(n);
        k++;
        turn_pending = 1'b1;
        if (k < 3) cpu_addr = a[k]; else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    n_cmp++;
    if (acks.size() != 3) begin
      n_err++;
      $display("FAIL b2b ack count: got %0d want 3", acks.size());
    end else begin
      n_cmp++;
      if (acks[0] != 3 + WS || acks[1] - acks[0] != 4 + WS || acks[2] - acks[1] != 4 + WS) begin
        n_err++;
        $display("FAIL b2b spacing: acks at %0d,%0d,%0d want first %0d then every %0d",
                 acks[0], acks[1], acks[2], 3 + WS, 4 + WS);
      end
    end
  endtask

  task automatic test_contention();
    bit seq[$];
    int n = 0;
    int n_cpu = 0, n_wb = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cpu_rd = 8'h00;
    exp_wb_rd  = 8'h00;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'h1;
    wbs_adr_i = 32'h0000_0033; wbs_dat_i = 32'h0;
    while (seq.size() < 20 && n < 20 * (4 + WS) + 20) begin
      @(negedge clk);
      n++;
      if (cpu_ack)   begin seq.push_back(1'b0); n_cpu++; end
      if (wbs_ack_o) begin seq.push_back(1'b1); n_wb++;  end
    end
    drop_requests();
    n_cmp++;
    if (seq.size() != 20) begin
      n_err++;
      $display("FAIL contention ack count: got %0d want 20", seq.size());
    end
`ifdef AS2650_ARB_ROUNDROBIN_EN
    for (int i = 0; i < seq.size(); i++) begin
      n_cmp++;
      if (seq[i] !== 1'(i % 2)) begin
        n_err++;
        $display("FAIL rr grant %0d: got %s want %s", i, seq[i] ? "WB" : "CPU", (i % 2) ? "WB" : "CPU");
      end
    end
    exp_wb_rd = exp_read(15'h0033);
`else
    n_cmp++;
    if (n_wb != 0 || n_cpu != 20) begin
      n_err++;
      $display("FAIL fixed priority: cpu acks %0d wb acks %0d want 20/0", n_cpu, n_wb);
    end
`endif
    exp_cpu_rd = exp_read(15'h0100);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int n_ack = 0;
    logic [7:0] old_byte;
    old_byte = exp_read(15'h0200);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'h1;
    wbs_adr_i = 32'h0000_0200; wbs_dat_i = 32'h0000_0055;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_we_n !== 1'b0) begin
      n_err++;
      $display("FAIL abort precondition: mem_we_n=%b want 0 in ACCESS", mem_we_n);
    end
    rst = 1'b1;
    drop_requests();
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack, wbs_ack_o} !== 6'b111100) begin
      n_err++;
      $display("FAIL abort strobes: got %b want 111100",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_data_oeb, cpu_ack, wbs_ack_o});
    end
    exp_cpu_rd = 8'h00;
    exp_wb_rd  = 8'h00;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack || wbs_ack_o) n_ack++;
    end
    n_cmp++;
    if (n_ack != 0) begin
      n_err++;
      $display("FAIL abort ack: got %0d acks want 0", n_ack);
    end
    do_access(1'b0, 1'b0, 15'h0200, 8'h00, 4'h1, "abort_readback");
    n_cmp++;
    if (cpu_rdata !== old_byte) begin
      n_err++;
      $display("FAIL abort old byte: got %h want %h", cpu_rdata, old_byte);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    test_reset();
    test_cpu_read();
    test_wb_write();
    test_wb_write_nosel();
    test_random();
    test_back_to_back();
    test_contention();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/as2650_mem_arbiter.md
Name: as2650_mem_arbiter

Overview:
- Shares one external asynchronous SRAM port (IO pads) between two requesters: the AS2650 CPU external bus and the Caravel Wishbone slave port.
- The management SoC can therefore load and inspect program memory while the CPU runs or is halted.
- Sits inside wrapped_as2650, between the CPU core and the pad drivers.
- Sequences each access as setup, then a programmable number of wait states, then an acknowledge.

Parameters:
- ADDR_W, 15, SRAM byte-address width; matches the AS2650 address space.
- WAIT_STATES, 1, extra ACCESS cycles beyond the first; legal range 0..7.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data; valid while cpu_ack=1
- cpu_ack  out  1  single-cycle completion pulse
- wbs_cyc_i  in  1  Wishbone cycle (already address-decoded upstream)
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  byte select; only bit 0 is used
- wbs_adr_i  in  32  byte address; bits [ADDR_W-1:0] are used
- wbs_dat_i  in  32  write data; bits [7:0] are used
- wbs_dat_o  out  32  {24'h0, read byte}
- wbs_ack_o  out  1  single-cycle acknowledge
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data
- mem_ce_n  out  1  chip enable, active low
- mem_oe_n  out  1  output enable, active low
- mem_we_n  out  1  write enable, active low
- mem_data_oeb  out  1  pad output-enable bar for the data pins (0 = chip drives)

Behaviour:
- Reset values: mem_ce_n=mem_oe_n=mem_we_n=mem_data_oeb=1; all acks 0; mem_addr, mem_wdata, cpu_rdata, wbs_dat_o all 0; state=IDLE; wait counter 0; last_grant=WB.
- Reset asserted mid-transaction aborts immediately to the reset values; no ack is issued for the aborted access.
- WB request = wbs_cyc_i & wbs_stb_i. A WB write with wbs_sel_i[0]=0 still completes and acks, but mem_we_n stays 1.
- IDLE:
  - Arbitrate between requesters; with no request, stay in IDLE.
  - Latch grant, address, we and wdata from the winner, then go to SETUP.
- SETUP (1 cycle):
  - mem_ce_n=0; mem_addr valid.
  - Read: mem_oe_n=0.
  - Write: mem_data_oeb=0, mem_wdata valid.
  - Load wait counter with WAIT_STATES; go to ACCESS.
- ACCESS:
  - Write: mem_we_n=0; all other SETUP strobes held.
  - Counter decrements each cycle. When the counter is 0, a read captures mem_rdata into the granted requester's read register, and the FSM goes to DONE.
  - Duration is WAIT_STATES+1 cycles.
- DONE (1 cycle):
  - Granted ack=1, with read data valid in the same cycle.
  - mem_we_n=1, mem_oe_n=1; mem_ce_n stays 0 for hold; mem_data_oeb stays 0 on writes.
  - Next state is IDLE.
- The forced IDLE cycle is the bus-turnaround cycle: all strobes and mem_data_oeb are 1.
- Latency, request seen in IDLE to ack: 3+WAIT_STATES cycles. Back-to-back throughput: one access per 4+WAIT_STATES cycles.
- Requester obligations:
  - A requester must deassert in the cycle after its ack; a request still high in IDLE is a new access.
  - Inputs may change once the request is latched; the latched copies are used.
- Default arbitration is fixed priority, CPU over WB. Simultaneous requests in IDLE grant the CPU; WB can starve under a continuous CPU stream.
- cpu_rdata holds its last read value and changes only on CPU-granted reads. wbs_dat_o behaves the same way for WB-granted reads.
- WAIT_STATES above 7 is a synthesis-time error.

Optional Feature:
- Macro AS2650_ARB_ROUNDROBIN_EN.
- Defined: on simultaneous requests in IDLE, the requester not equal to last_grant wins. last_grant updates at every grant; its reset value is WB, so the first contention goes to the CPU.
- Undefined: fixed CPU priority as above; last_grant is not implemented.

Decomposition:
- Package as2650_mem_pkg holds:
  - the state enum {IDLE, SETUP, ACCESS, DONE};
  - the grant enum {GNT_CPU, GNT_WB};
  - the constant WAIT_MAX=7.
- No sub-module. The arbitration decision is a small function inside the package.

Test Plan:
- CPU read, WAIT_STATES=1, SRAM model holds 8'hA5 at 15'h0100; cpu_req pulse: cpu_ack arrives 4 cycles after req, cpu_rdata=8'hA5; mem_oe_n low for exactly 3 cycles.
- WB write of 0x3C to 0x7FFF with sel=4'h1: mem_we_n low exactly 2 cycles, never overlapping the SETUP cycle; mem_data_oeb low from SETUP through DONE; SRAM byte 0x7FFF=0x3C; wbs_ack_o one cycle.
- WB write with sel=4'h0: wbs_ack_o is asserted, mem_we_n stays 1, SRAM is unchanged.
- CPU and WB requests in the same cycle, each held continuously:
  - Default build: the CPU is served repeatedly and WB is never acked within 20 accesses.
  - With AS2650_ARB_ROUNDROBIN_EN: grants alternate CPU, WB, CPU, WB.
- wb_rst_i asserted for 1 cycle during ACCESS of a write: the next cycle shows all strobes=1 and mem_data_oeb=1, no ack, state IDLE; a subsequent read of the same address returns the old byte.
- WAIT_STATES=0, back-to-back CPU reads: successive acks are 4 cycles apart, with one all-strobes-high turnaround cycle between accesses.
